// File: rtl/ssl_pkg.sv
// ssl_pkg: shared types and helpers for the ssl delay-estimator back end.
//   ndata_log()  - index width derivation for a frame length
//   NDATA_DEF    - default frame length (clk cycles, also delay-index range)
//   MID          - zero-lag index (NDATA_DEF/2)
//   idx_t/lag_t  - unsigned delay index / signed lag, both NDATA_LOG wide
//   median3()    - middle of three unsigned indices
package ssl_pkg;

  function automatic int ndata_log(input int n);
    return $clog2(n);
  endfunction

  localparam int NDATA_DEF = 128;
  localparam int NDATA_LOG = ndata_log(NDATA_DEF);
  localparam int MID       = NDATA_DEF / 2;

  typedef logic        [NDATA_LOG-1:0] idx_t;
  typedef logic signed [NDATA_LOG-1:0] lag_t;

  // Ties fall out naturally: a tied pair always satisfies one of the range tests.
  function automatic idx_t median3(input idx_t a, input idx_t b, input idx_t c);
    idx_t m;
    if ((a >= b && a <= c) || (a <= b && a >= c)) begin
      m = a;
    end else if ((b >= a && b <= c) || (b <= a && b >= c)) begin
      m = b;
    end else begin
      m = c;
    end
    return m;
  endfunction

endpackage

// File: rtl/tdoa_track_if.sv
// tdoa_track_if: bundle between the delay estimator, tdoa_track and the
// direction logic.
//   dIdA/B/C  - free-running delay indices (estimator -> tracker)
//   lagA/B/C  - signed median lags (tracker -> consumer)
//   valid     - one-cycle pulse when the lags update
//   locked    - all lags stable for HOLD frames
// master: the environment side; slave: the tdoa_track side.
interface tdoa_track_if;
  import ssl_pkg::*;

  idx_t dIdA;
  idx_t dIdB;
  idx_t dIdC;
  lag_t lagA;
  lag_t lagB;
  lag_t lagC;
  logic valid;
  logic locked;

  modport master (output dIdA, dIdB, dIdC, input lagA, lagB, lagC, valid, locked);
  modport slave  (input dIdA, dIdB, dIdC, output lagA, lagB, lagC, valid, locked);
endinterface

// File: rtl/tdoa_median3.sv
// tdoa_median3: one channel of the tracker. Keeps a 3-deep history of the
// delay index captured on each frame strobe and presents the median of that
// history as a signed lag about MID.
//   clk, rst - clock, async active-high reset (history clears to 0)
//   shift    - frame strobe; captures din into the history
//   din      - delay index
//   lag      - median(history) - MID, combinational from the history regs
module tdoa_median3
  import ssl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  idx_t din,
  output lag_t lag
);

  localparam idx_t MID_I = idx_t'(MID);

  idx_t h0_r;
  idx_t h1_r;
  idx_t h2_r;
  idx_t med_s;

  // history shift register, advanced once per frame strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0_r <= '0;
      h1_r <= '0;
      h2_r <= '0;
    end else if (shift) begin
      h0_r <= din;
      h1_r <= h0_r;
      h2_r <= h1_r;
    end else begin
      h0_r <= h0_r;
      h1_r <= h1_r;
      h2_r <= h2_r;
    end
  end

  // median and offset; dropping the extra top bit of a widened subtraction
  // gives the same two's-complement result, so subtract at native width
  always_comb begin
    med_s = median3(h0_r, h1_r, h2_r);
    lag   = lag_t'(med_s - MID_I);
  end

endmodule

// File: rtl/tdoa_track.sv
// tdoa_track: samples the three delay indices once per NDATA-cycle frame,
// median-filters each over three frames and reports signed lags with a
// per-frame valid pulse and a stability lock flag.
//   clk  - system clock (rising edge)
//   erst - asynchronous active-high reset
//   bus  - tdoa_track_if.slave: dIdA/B/C in; lagA/B/C, valid, locked out
// Optional build macro SUM_CHECK_EN: rejects frames whose three lags do not
// close (|lagA+lagB+lagC| > 2*TOL); a rejected frame holds the outputs,
// raises no valid and clears the stability count.
module tdoa_track
  import ssl_pkg::*;
#(
  parameter int NDATA = NDATA_DEF,
  parameter int HOLD  = 4,
  parameter int TOL   = 2
) (
  input logic         clk,
  input logic         erst,
  tdoa_track_if.slave bus
);

  localparam idx_t                 CNT_LAST = idx_t'(NDATA - 1);
  localparam logic [3:0]           HOLD_W   = HOLD[3:0];
  localparam logic [NDATA_LOG:0]   TOL_W    = TOL[NDATA_LOG:0];

  idx_t       cnt_r;
  logic [1:0] fill_r;
  logic       pend_r;
  logic       valid_r;
  logic       have_prev_r;
  logic [3:0] stable_r;
  lag_t       lag_a_r, lag_b_r, lag_c_r;
  lag_t       med_a_s, med_b_s, med_c_s;
  logic       strobe_s;
  logic       near_s;
  logic       accept_s;

  // |a - b| in one extra bit so a full-range swing cannot wrap
  function automatic logic [NDATA_LOG:0] lag_absdiff(input lag_t a, input lag_t b);
    logic signed [NDATA_LOG:0] d;
    d = $signed({a[NDATA_LOG-1], a}) - $signed({b[NDATA_LOG-1], b});
    return d[NDATA_LOG] ? (NDATA_LOG+1)'(-d) : (NDATA_LOG+1)'(d);
  endfunction

  assign strobe_s = (cnt_r == CNT_LAST);

  tdoa_median3 u_med_a (.clk(clk), .rst(erst), .shift(strobe_s), .din(bus.dIdA), .lag(med_a_s));
  tdoa_median3 u_med_b (.clk(clk), .rst(erst), .shift(strobe_s), .din(bus.dIdB), .lag(med_b_s));
  tdoa_median3 u_med_c (.clk(clk), .rst(erst), .shift(strobe_s), .din(bus.dIdC), .lag(med_c_s));

  // stability of the candidate lags against the last reported ones
  always_comb begin
    near_s = (lag_absdiff(med_a_s, lag_a_r) <= TOL_W) &&
             (lag_absdiff(med_b_s, lag_b_r) <= TOL_W) &&
             (lag_absdiff(med_c_s, lag_c_r) <= TOL_W);
  end

`ifdef SUM_CHECK_EN
  localparam int                   SUM_LIM_I = 2 * TOL;
  localparam logic [NDATA_LOG+1:0] SUM_LIM   = SUM_LIM_I[NDATA_LOG+1:0];
  logic signed [NDATA_LOG+1:0] sum_s;
  logic        [NDATA_LOG+1:0] sum_abs_s;

  // closure check: the three pairwise lags of a real source sum to ~0
  always_comb begin
    sum_s = (NDATA_LOG+2)'(med_a_s) + (NDATA_LOG+2)'(med_b_s) + (NDATA_LOG+2)'(med_c_s);
    if (sum_s[NDATA_LOG+1]) begin
      sum_abs_s = -sum_s;
    end else begin
      sum_abs_s = sum_s;
    end
    accept_s = (sum_abs_s <= SUM_LIM);
  end
`else
  assign accept_s = 1'b1;
`endif

  // frame counter, warm-up fill, lag/valid registers and stability count
  always_ff @(posedge clk or posedge erst) begin
    if (erst) begin
      cnt_r       <= '0;
      fill_r      <= 2'd0;
      pend_r      <= 1'b0;
      valid_r     <= 1'b0;
      have_prev_r <= 1'b0;
      stable_r    <= 4'd0;
      lag_a_r     <= '0;
      lag_b_r     <= '0;
      lag_c_r     <= '0;
    end else begin
      cnt_r   <= strobe_s ? '0 : cnt_r + idx_t'(1);
      valid_r <= 1'b0;
      // the capture on this strobe is the one that completes the history
      pend_r  <= strobe_s && (fill_r >= 2'd2);
      if (strobe_s && fill_r != 2'd3) begin
        fill_r <= fill_r + 2'd1;
      end
      if (pend_r) begin
        if (accept_s) begin
          lag_a_r     <= med_a_s;
          lag_b_r     <= med_b_s;
          lag_c_r     <= med_c_s;
          valid_r     <= 1'b1;
          have_prev_r <= 1'b1;
          if (!have_prev_r || !near_s) begin
            stable_r <= 4'd0;
          end else if (stable_r != HOLD_W) begin
            stable_r <= stable_r + 4'd1;
          end
        end else begin
          stable_r <= 4'd0;
        end
      end
    end
  end

  assign bus.lagA   = lag_a_r;
  assign bus.lagB   = lag_b_r;
  assign bus.lagC   = lag_c_r;
  assign bus.valid  = valid_r;
  assign bus.locked = (stable_r == HOLD_W);

endmodule

// File: tb/tb_tdoa_track.sv
module tb_tdoa_track;
  import ssl_pkg::*;

  localparam int NDATA = 128;
  localparam int HOLD  = 4;
  localparam int TOL   = 2;
  localparam int HALF  = NDATA / 2;

  logic clk  = 1'b0;
  logic erst = 1'b1;
  always #5 clk = ~clk;

  tdoa_track_if bus ();

  tdoa_track #(.NDATA(NDATA), .HOLD(HOLD), .TOL(TOL)) dut (
    .clk (clk),
    .erst(erst),
    .bus (bus)
  );

  typedef struct {
    int la;
    int lb;
    int lc;
    bit lk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // reference model state: raw captured indices per frame
  int hist_a[$], hist_b[$], hist_c[$];
  int prev_a, prev_b, prev_c;
  bit have_prev;
  int stable;
  int cur_a, cur_b, cur_c;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int med3(input int a, input int b, input int c);
    int mx, mn;
    mx = (a > b) ? a : b;
    mx = (mx > c) ? mx : c;
    mn = (a < b) ? a : b;
    mn = (mn < c) ? mn : c;
    return a + b + c - mx - mn;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    hist_a.delete(); hist_b.delete(); hist_c.delete();
    prev_a = 0; prev_b = 0; prev_c = 0;
    have_prev = 1'b0;
    stable = 0;
    exp_q.delete();
  endtask

  // one frame's capture as seen by the model
  task automatic model_frame(input int a, input int b, input int c);
    exp_t e;
    int la, lb, lc;
    hist_a.push_back(a); hist_b.push_back(b); hist_c.push_back(c);
    if (hist_a.size() > 3) begin
      void'(hist_a.pop_front()); void'(hist_b.pop_front()); void'(hist_c.pop_front());
    end
    if (hist_a.size() == 3) begin
      la = med3(hist_a[0], hist_a[1], hist_a[2]) - HALF;
      lb = med3(hist_b[0], hist_b[1], hist_b[2]) - HALF;
      lc = med3(hist_c[0], hist_c[1], hist_c[2]) - HALF;
`ifdef SUM_CHECK_EN
      if (iabs(la + lb + lc) > 2 * TOL) begin
        stable = 0;
        return;
      end
`endif
      if (!have_prev) begin
        stable = 0;
      end else if (iabs(la - prev_a) <= TOL && iabs(lb - prev_b) <= TOL && iabs(lc - prev_c) <= TOL) begin
        stable = (stable < HOLD) ? stable + 1 : HOLD;
      end else begin
        stable = 0;
      end
      have_prev = 1'b1;
      prev_a = la; prev_b = lb; prev_c = lc;
      e.la = la; e.lb = lb; e.lc = lc; e.lk = (stable == HOLD);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input int a, input int b, input int c);
    bus.dIdA = idx_t'(a);
    bus.dIdB = idx_t'(b);
    bus.dIdC = idx_t'(c);
  endtask

  // entered on a negedge; ends on the negedge after this frame's strobe edge
  task automatic run_frame(input int a, input int b, input int c, input bit junk);
    if (junk) begin
      drive($urandom_range(0, NDATA - 1), $urandom_range(0, NDATA - 1), $urandom_range(0, NDATA - 1));
      repeat (HALF) @(posedge clk);
      @(negedge clk);
      drive(a, b, c);
      repeat (HALF) @(posedge clk);
    end else begin
      drive(a, b, c);
      repeat (NDATA) @(posedge clk);
    end
    model_frame(a, b, c);
    cur_a = a; cur_b = b; cur_c = c;
    @(negedge clk);
  endtask

  function automatic int jitter(input int v);
    int n;
    n = v + $urandom_range(0, 4) - 2;
    if (n < 0) n = 0;
    if (n > NDATA - 1) n = NDATA - 1;
    return n;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!erst && bus.valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got valid=1 expected no output at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("lagA", int'(bus.lagA), e.la);
        chk("lagB", int'(bus.lagB), e.lb);
        chk("lagC", int'(bus.lagC), e.lc);
        chk("locked", int'(bus.locked), int'(e.lk));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cur_a = 0; cur_b = 0; cur_c = 0;
    drive(0, 0, 0);
    // reset held with toggling inputs
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive($urandom_range(0, NDATA - 1), $urandom_range(0, NDATA - 1), $urandom_range(0, NDATA - 1));
    end
    @(negedge clk);
    chk("rst_lagA", int'(bus.lagA), 0);
    chk("rst_lagB", int'(bus.lagB), 0);
    chk("rst_lagC", int'(bus.lagC), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_locked", int'(bus.locked), 0);
    erst = 1'b0;

    // constant source: lags +6/-4/-2, lock on the 5th valid frame
    for (int i = 0; i < 8; i++) run_frame(70, 60, 62, 1'b0);
    // single-frame outlier on A is removed by the median
    run_frame(70, 60, 62, 1'b0);
    run_frame(70, 60, 62, 1'b0);
    run_frame(100, 60, 62, 1'b0);
    run_frame(70, 60, 62, 1'b0);
    run_frame(70, 60, 62, 1'b0);
    // step on A after lock
    for (int i = 0; i < 8; i++) run_frame(80, 60, 62, 1'b0);
    // index extremes and a full-range swing
    for (int i = 0; i < 3; i++) run_frame(0, 60, 62, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(127, 60, 62, 1'b0);

    // rebuild lock, then reset mid-frame
    for (int i = 0; i < 7; i++) run_frame(70, 60, 62, 1'b0);
    chk("pre_rst_locked", int'(bus.locked), int'(stable == HOLD));
    drive(70, 60, 62);
    repeat (60) @(posedge clk);
    #2;
    erst = 1'b1;
    #1;
    chk("midrst_lagA", int'(bus.lagA), 0);
    chk("midrst_lagB", int'(bus.lagB), 0);
    chk("midrst_lagC", int'(bus.lagC), 0);
    chk("midrst_valid", int'(bus.valid), 0);
    chk("midrst_locked", int'(bus.locked), 0);
    model_reset();
    @(negedge clk);
    erst = 1'b0;

    // inputs wiggling between strobes must not matter
    for (int i = 0; i < 4; i++) run_frame(66, 62, 64, 1'b1);

    // randomized frames: mostly small drift, sometimes a jump
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_frame($urandom_range(0, NDATA - 1), $urandom_range(0, NDATA - 1), $urandom_range(0, NDATA - 1), 1'($urandom_range(0, 1)));
      end else begin
        run_frame(jitter(cur_a), jitter(cur_b), jitter(cur_c), 1'($urandom_range(0, 1)));
      end
    end

    // closure-violating source (C lag +16)
    for (int i = 0; i < 5; i++) run_frame(70, 60, 80, 1'b0);

    repeat (4) @(negedge clk);
    chk("pending_outputs", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tdoa_track.md
Name: tdoa_track

Overview:
- Downstream stage of the ssl delay estimator. Consumes its three free-running delay indices dIdA/dIdB/dIdC, which have no valid strobe.
- Samples them once per NDATA-cycle frame, applies a 3-tap median per channel and converts each index to a signed lag about NDATA/2.
- Reports per-frame valid plus a lock flag once all lags have stayed stable for HOLD frames. Feeds the direction/sector logic.

Parameters:
- NDATA, 128: frame length in clk cycles; index range of dId inputs; NDATA_LOG = $clog2(NDATA).
- HOLD, 4: consecutive stable frames required for lock (1..15).
- TOL, 2: max per-channel |lag change| between consecutive valid frames still counted as stable.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- erst  in  1  asynchronous, active-high reset.
- dIdA  in  NDATA_LOG  delay index, pair mic0-mic1.
- dIdB  in  NDATA_LOG  delay index, pair mic1-mic2.
- dIdC  in  NDATA_LOG  delay index, pair mic2-mic0.
- lagA  out  NDATA_LOG  signed median lag A = median(dIdA) - NDATA/2.
- lagB  out  NDATA_LOG  signed median lag B.
- lagC  out  NDATA_LOG  signed median lag C.
- valid  out  1  one-cycle pulse when lagA/B/C update.
- locked  out  1  high while stable count == HOLD.

Behaviour:
- Reset (erst=1, async): frame counter=0, history regs=0, fill=0, lagA/B/C=0, valid=0, stable count=0, locked=0.
- Frame counter runs 0..NDATA-1 and wraps. The strobe is cnt==NDATA-1. The first strobe is on the 128th rising edge after erst deasserts (NDATA=128).
- On each strobe, every channel shifts its current input into a 3-deep history. fill saturates at 3.
- If fill (including the current capture) reaches 3, the following cycle:
  - lagX <= median3(history) - NDATA/2, computed in NDATA_LOG+1 bits and truncated to NDATA_LOG two's-complement (range -NDATA/2..NDATA/2-1);
  - valid pulses for 1 cycle.
  - Latency: strobe cycle +1.
- If fill < 3: no valid; outputs hold.
- Median: middle of three unsigned values. Ties return the tied value.
- Stability is evaluated on each valid frame:
  - First valid frame after reset: stable count = 0.
  - Later frames: if |new lagX - prev lagX| <= TOL for all X, stable count increments, saturating at HOLD. Otherwise it clears to 0.
  - The difference is computed in NDATA_LOG+1 bits, so there is no wrap.
- locked is combinational on (stable count == HOLD), which is a registered value. It drops on the same cycle as the valid pulse that clears the count.
- Outputs hold between valid pulses. Input changes between strobes are ignored.
- erst mid-frame: everything clears immediately. Warm-up (3 strobes) restarts from the counter's zero.

Optional Feature:
- Macro SUM_CHECK_EN enables a closure check.
- Defined:
  - On a would-be valid frame, compute s = lagA + lagB + lagC in NDATA_LOG+2 bits.
  - If |s| > 2*TOL, the frame is rejected: lag outputs hold, valid stays 0, stable count clears to 0, and history still shifts.
  - Accepted frames behave as above.
- Undefined: no check; every frame with fill==3 is valid.

Decomposition:
- Package ssl_pkg:
  - NDATA_LOG derivation helper;
  - lag_t (signed NDATA_LOG) and idx_t (unsigned NDATA_LOG) typedefs;
  - MID = NDATA/2 constant;
  - median3 function.
- One sub-module, tdoa_median3: per-channel 3-deep history + median + offset subtraction. Instantiated 3 times.
- Frame counter, stability counter and sum check stay in the top module.

Test Plan:
- erst held 1, inputs toggling -> lagA/B/C=0, valid=0, locked=0. Assert erst mid-frame (cnt≈60) -> all outputs 0 within the same cycle.
- dIdA=70, dIdB=60, dIdC=62 constant from reset release -> first valid at cycle 384 with lagA=+6, lagB=-4, lagC=-2; valid at 512, 640, …; locked rises at cycle 896 (5th valid frame).
- Median: dIdA per frame 70,70,100,70,70 with B/C fixed -> lagA stays +6 every valid frame; locked unaffected.
- Step: after lock, dIdA jumps 70->80 for all subsequent frames -> lagA +6->+16 on the 2nd frame after the step; locked drops on that valid; relocks HOLD frames later.
- Extremes: dIdA=0 -> lagA=-64; dIdA=127 -> lagA=+63; no wrap in the stability difference (0->127 clears stable count).
- SUM_CHECK_EN defined: dIdC=80 (lagC=+16, sum=18 > 4) -> no valid, outputs hold, locked=0. Undefined: same stimulus -> valid pulses with lagC=+16.
